// File: rtl/med_window_filter.sv
// med_window_filter: self-sequenced rank-order filter over a valid/ready pixel stream.
// Collects NUMBER samples. Repeated max-extraction passes on one compare element then
// find the requested rank. BYP (latched per window) returns the centre pixel with the
// same latency instead.
// Optional feature macro: MED_RANK_SEL_EN. It adds a runtime RANK_SEL port, which is
// latched per window and clamped to NUMBER-1.
module med_window_filter #(
  parameter int WIDTH  = 8,
  parameter int NUMBER = 9,
  parameter int RANK   = (NUMBER - 1) / 2
) (
  input  logic                      CLK,
  input  logic                      nRST,
  input  logic [WIDTH-1:0]          DI,
  input  logic                      DI_VALID,
  output logic                      DI_READY,
  input  logic                      BYP,
  output logic [WIDTH-1:0]          DO,
  output logic                      DO_VALID,
  input  logic                      DO_READY
`ifdef MED_RANK_SEL_EN
  ,
  input  logic [$clog2(NUMBER)-1:0] RANK_SEL
`endif
);

  localparam int CW = $clog2(NUMBER);
  localparam int PW = $clog2(NUMBER + 1);
  localparam logic [CW-1:0] LAST_C = CW'(NUMBER - 1);
  localparam int CTR_POS = (NUMBER - 3) / 2;

  typedef enum logic [1:0] {
    S_LOAD,
    S_SORT,
    S_LAST,
    S_OUT
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] chain_q [NUMBER];
  logic [WIDTH-1:0] chain_d [NUMBER];
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] ctr_q, ctr_d;
  logic [WIDTH-1:0] do_q, do_d;
  logic             byp_q, byp_d;
  logic [CW-1:0]    cyc_q, cyc_d;
  logic [PW-1:0]    pass_q, pass_d;
  logic [PW-1:0]    passes;
  logic [WIDTH-1:0] tail, big_v, small_v;

`ifdef MED_RANK_SEL_EN
  localparam logic [CW-1:0] RMAX  = CW'(NUMBER - 1);
  localparam logic [PW-1:0] NUM_P = PW'(NUMBER);
  logic [CW-1:0] rank_q, rank_d;

  // Per-window rank latch
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) rank_q <= '0;
    else       rank_q <= rank_d;
  end

  // Latch the clamped rank on the first transfer of a window
  always_comb begin
    rank_d = rank_q;
    if (state_q == S_LOAD && DI_VALID && cyc_q == '0)
      rank_d = (RANK_SEL > RMAX) ? RMAX : RANK_SEL;
  end

  assign passes = NUM_P - PW'(rank_q);
`else
  localparam logic [PW-1:0] PASSES = PW'(NUMBER - RANK);
  assign passes = PASSES;
`endif

  // The compare element sits on the chain tail against the running-max accumulator
  assign tail    = chain_q[NUMBER-1];
  assign big_v   = (tail > acc_q) ? tail : acc_q;
  assign small_v = (tail > acc_q) ? acc_q : tail;

  // State, sample chain and datapath registers
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= S_LOAD;
      chain_q <= '{default: '0};
      acc_q   <= '0;
      ctr_q   <= '0;
      do_q    <= '0;
      byp_q   <= 1'b0;
      cyc_q   <= '0;
      pass_q  <= '0;
    end else begin
      state_q <= state_d;
      chain_q <= chain_d;
      acc_q   <= acc_d;
      ctr_q   <= ctr_d;
      do_q    <= do_d;
      byp_q   <= byp_d;
      cyc_q   <= cyc_d;
      pass_q  <= pass_d;
    end
  end

  // Next-state and datapath control
  // Each pass rotates the chain once through the compare element. Smaller values go back
  // to the head, and the accumulator ends holding the pass maximum. Clearing the
  // accumulator to 0 at the end of a pass removes that maximum from the working set. The
  // spare zeros never exceed a real sample, so the P-th maximum is rank r. One extra
  // S_LAST cycle registers DO before DO_VALID rises.
  always_comb begin
    state_d = state_q;
    chain_d = chain_q;
    acc_d   = acc_q;
    ctr_d   = ctr_q;
    do_d    = do_q;
    byp_d   = byp_q;
    cyc_d   = cyc_q;
    pass_d  = pass_q;
    unique case (state_q)
      S_LOAD: begin
        if (DI_VALID) begin
          chain_d[0] = DI;
          for (int unsigned i = 1; i < NUMBER; i++) chain_d[i] = chain_q[i-1];
          if (cyc_q == '0) byp_d = BYP;
          if (cyc_q == LAST_C) begin
            // Centre pixel (arrival index (NUMBER-1)/2) sits at CTR_POS before this shift
            ctr_d   = chain_q[CTR_POS];
            cyc_d   = '0;
            pass_d  = '0;
            acc_d   = '0;
            state_d = S_SORT;
          end else begin
            cyc_d = cyc_q + 1'b1;
          end
        end
      end
      S_SORT: begin
        chain_d[0] = small_v;
        for (int unsigned i = 1; i < NUMBER; i++) chain_d[i] = chain_q[i-1];
        acc_d = big_v;
        if (cyc_q == LAST_C) begin
          cyc_d = '0;
          acc_d = '0;
          if (pass_q == passes - 1'b1) begin
            do_d    = byp_q ? ctr_q : big_v;
            state_d = S_LAST;
          end else begin
            pass_d = pass_q + 1'b1;
          end
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end
      S_LAST: state_d = S_OUT;
      S_OUT:  if (DO_READY) state_d = S_LOAD;
      default: state_d = S_LOAD;
    endcase
  end

  assign DI_READY = (state_q == S_LOAD);
  assign DO_VALID = (state_q == S_OUT);
  assign DO       = do_q;

endmodule
